// File: rtl/reg_arb_pkg.sv
// Shared definitions for the round-robin register write arbiter.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        ACK  = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit searching upward from last_grant+1.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        int cand;
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_grant_i) + k) % N_REQ;
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a shared register,
// with a registered four-phase req/ack handshake.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       q,
    output logic                   busy,
    output logic [IDX_W-1:0]       owner
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i        (req),
        .last_grant_i (last_q),
        .valid_o      (pick_vld),
        .idx_o        (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    // Only the granted requester's data is ever sampled, and only in LOAD.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        ack_d   = ack_q;
        busy_d  = busy_q;
        q_d     = q_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (req[grant_q]) begin
                    q_d            = wdata[grant_q*WIDTH +: WIDTH];
                    ack_d          = '0;
                    ack_d[grant_q] = 1'b1;
                    state_d        = ACK;
                end else begin
                    last_d  = grant_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            ACK: begin
                if (!req[grant_q]) begin
                    ack_d   = '0;
                    last_d  = grant_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign ack   = ack_q;
    assign q     = q_q;
    assign busy  = busy_q;
    assign owner = grant_q;

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares one WIDTH-bit storage register between N_REQ requesters.
- Each requester raises a level request with write data.
- The block grants one requester at a time, round-robin, loads its data into the register, and returns a four-phase req/ack handshake.
- It sits in front of the flip-flop register datapath and is the only writer of that register.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, register and write-data width in bits
- IDX_W, $clog2(N_REQ), width of the grant/owner index (derived, not overridable)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N_REQ  per-requester write request (level)
- wdata  input  N_REQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH]
- ack  output  N_REQ  per-requester acknowledge, one-hot or zero
- q  output  WIDTH  current register contents
- busy  output  1  high whenever state is not IDLE
- owner  output  IDX_W  index of the requester currently or last granted

Behaviour:
- Reset: rst_n low forces state IDLE, q=0, ack=0, busy=0, owner=0, last_grant=N_REQ-1. This applies immediately and asynchronously, including mid-transaction.
- Reset priority: because last_grant resets to N_REQ-1, requester 0 has first priority after reset.
- States: IDLE, LOAD, ACK. All outputs are registered; there are no combinational paths from inputs to outputs.
- IDLE:
  - If any req bit is high at a rising edge, select the first high bit searching upward from last_grant+1, wrapping modulo N_REQ.
  - Latch the selected index into grant/owner, set busy=1, and go to LOAD.
  - If no req bit is high, stay in IDLE.
- LOAD:
  - If req[grant] is still high at the edge: q <= wdata[grant], ack[grant] <= 1, go to ACK.
  - If req[grant] has dropped (abort): q is unchanged, no ack, last_grant <= grant, go to IDLE, busy=0.
- ACK:
  - Hold ack[grant]=1 and q stable until req[grant] is sampled low.
  - On that edge: ack <= 0, last_grant <= grant, busy <= 0, go to IDLE.
  - The earliest next grant decision is the following edge.
- Latency: req sampled at edge E0 gives q updated and ack high after edge E1, i.e. 2 cycles from request to acknowledge.
- Minimum transaction length is 4 cycles, including the handshake release and the return to IDLE.
- Requester obligations: hold wdata stable from raising req until ack is seen; do not drop req between ack rising and the release.
- Non-granted requests stay pending and untouched, with no starvation.
- Round-robin bound: with all requesters continuously requesting, the grant order is 0,1,..,N_REQ-1,0,...; every requester is served within N_REQ transactions.
- Simultaneous events: a new req edge arriving during LOAD or ACK is only considered at the next IDLE arbitration.
- X handling: wdata of non-granted requesters is never sampled.
- Width rules: q takes exactly WIDTH bits with no extension; owner wraps modulo N_REQ.
- owner holds its value in IDLE and shows the last granted index.

Decomposition:
- Shared package reg_arb_pkg holds:
  - the state encoding enum (IDLE=2'b00, LOAD=2'b01, ACK=2'b10)
  - the localparam for the default WIDTH
- One sub-module, rr_pick, is natural: a combinational round-robin selector. Inputs are req vector and last_grant; outputs are a valid flag and the selected index.
- The storage register stays inline in reg_write_arbiter as a single always block with asynchronous reset.

Test Plan:
- Reset then single request: deassert rst_n, raise req[2] with wdata[2]=8'hA5 → ack[2] high two edges later, q=8'hA5, owner=2, busy=1; drop req[2] → ack=0 and busy=0 next edge.
- All four requesting continuously with distinct data 8'h10/8'h21/8'h32/8'h43, each dropping and re-raising req after ack → grant order 0,1,2,3,0; q follows the same sequence.
- Abort: raise req[1], then drop it in the LOAD cycle → no ack, q keeps its prior value 8'h00, next arbitration starts from index 2.
- Asynchronous reset mid-ACK: rst_n pulsed low between edges while ack[3]=1 → q=0, ack=0, busy=0 immediately; after release, req[0] and req[3] both high → requester 0 granted first.
- Late request: req[0] is being served and req[1] rises during ACK → req[1] is not granted until the IDLE cycle after the release, then served with its data.
